// File: rtl/fact_pkg.sv
// -----------------------------------------------------------------------------
// fact_pkg
//   Shared definitions for the factorial / double-factorial engine.
//   - fact_state_e : engine FSM states (IDLE waits for a job, CALC iterates)
//   - MODE_FACT    : compute n!
//   - MODE_DFACT   : compute n!! (every second factor)
//   - cnt_decrement: how far the loop counter moves per multiply for a mode
// -----------------------------------------------------------------------------
package fact_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } fact_state_e;

    localparam logic MODE_FACT  = 1'b0;
    localparam logic MODE_DFACT = 1'b1;

    // Step size of the descending factor counter: 1 for n!, 2 for n!!.
    function automatic logic [1:0] cnt_decrement(input logic job_mode);
        return (job_mode == MODE_DFACT) ? 2'd2 : 2'd1;
    endfunction

endpackage : fact_pkg

// File: rtl/fact_mul_step.sv
// -----------------------------------------------------------------------------
// fact_mul_step
//   One iteration of the factorial loop, purely combinational.
//   Multiplies the running accumulator by the current factor at full
//   OUT_W+IN_W precision, flags overflow when any bit above OUT_W is set and
//   folds it into the job's sticky overflow flag.
//
//   Parameters
//     IN_W     : width of the factor (loop counter)
//     OUT_W    : width of the accumulator
//     SATURATE : 1 = clamp to all-ones once the job has overflowed,
//                0 = keep the low OUT_W bits (wrap modulo 2^OUT_W)
//
//   Ports
//     acc      in  OUT_W  running product
//     cnt      in  IN_W   current factor
//     ovf      in  1      sticky overflow of the job so far
//     acc_next out OUT_W  accumulator after this multiply
//     ovf_next out 1      sticky overflow after this multiply
// -----------------------------------------------------------------------------
module fact_mul_step #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 16,
    parameter int SATURATE = 0
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [IN_W-1:0]  cnt,
    input  logic             ovf,
    output logic [OUT_W-1:0] acc_next,
    output logic             ovf_next
);

    localparam int PROD_W = OUT_W + IN_W;

    logic [PROD_W-1:0] prod;
    logic              prod_ovf;

    always_comb begin
        prod     = PROD_W'(acc) * PROD_W'(cnt);
        // Anything in the top IN_W bits cannot be represented in the result.
        prod_ovf = |prod[PROD_W-1:OUT_W];
        ovf_next = ovf | prod_ovf;
    end

    generate
        if (SATURATE != 0) begin : g_saturate
            // Once the job has overflowed (now or earlier) the accumulator is
            // pinned to all-ones; further multiplies keep re-deriving it.
            assign acc_next = ovf_next ? {OUT_W{1'b1}} : prod[OUT_W-1:0];
        end else begin : g_wrap
            assign acc_next = prod[OUT_W-1:0];
        end
    endgenerate

endmodule : fact_mul_step

// File: rtl/fact_engine.sv
// -----------------------------------------------------------------------------
// fact_engine
//   Iterative n! / n!! engine behind a start/done handshake, one multiply per
//   clock. A job is accepted from IDLE on start, runs in CALC until the factor
//   counter reaches 0 or 1, then publishes the result with a one-cycle done
//   pulse. done and the return to IDLE coincide, so a new start in the done
//   cycle is accepted with no bubble.
//
//   Parameters
//     IN_W     : operand width
//     OUT_W    : accumulator / result width
//     SATURATE : 1 = clamp result to all-ones on overflow, 0 = wrap
//
//   Ports
//     clk       in  1      system clock, rising edge
//     reset_n   in  1      synchronous active-low reset (aborts any job)
//     start     in  1      job request, honoured only in IDLE
//     mode      in  1      0 = n!, 1 = n!!, latched on accept
//     fdata_in  in  IN_W   operand n, latched on accept
//     busy      out 1      high while a job is in CALC
//     done      out 1      one-cycle pulse, result valid
//     overflow  out 1      true result exceeded OUT_W bits; held with result
//     fdata_out out OUT_W  result, held until the next done
// -----------------------------------------------------------------------------
module fact_engine
    import fact_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [IN_W-1:0]  fdata_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [OUT_W-1:0] fdata_out
);

    fact_state_e      state_reg;
    logic [OUT_W-1:0] acc_reg;
    logic [IN_W-1:0]  cnt_reg;
    logic             mode_reg;
    logic             ovf_reg;
    logic             done_reg;
    logic             overflow_reg;
    logic [OUT_W-1:0] fdata_out_reg;

    logic [OUT_W-1:0] acc_next;
    logic             ovf_next;
    logic             cnt_le_one;
    logic [IN_W-1:0]  cnt_next;

    // -------------------------------------------------------------------------
    // Multiply datapath
    // -------------------------------------------------------------------------
    fact_mul_step #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .SATURATE (SATURATE)
    ) u_mul_step (
        .acc      (acc_reg),
        .cnt      (cnt_reg),
        .ovf      (ovf_reg),
        .acc_next (acc_next),
        .ovf_next (ovf_next)
    );

    // Loop terminates when no factor >= 2 remains. Checking the upper bits
    // for zero covers both 0 and 1 without a magnitude comparator.
    assign cnt_le_one = (cnt_reg[IN_W-1:1] == '0);

    // Only evaluated when cnt >= 2, so the n!! step never underflows.
    assign cnt_next = cnt_reg - IN_W'(cnt_decrement(mode_reg));

    // -------------------------------------------------------------------------
    // FSM, counters and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            acc_reg       <= OUT_W'(1);
            cnt_reg       <= '0;
            mode_reg      <= MODE_FACT;
            ovf_reg       <= 1'b0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            fdata_out_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg   <= OUT_W'(1);
                        cnt_reg   <= fdata_in;
                        mode_reg  <= mode;
                        ovf_reg   <= 1'b0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_le_one) begin
                        fdata_out_reg <= acc_reg;
                        overflow_reg  <= ovf_reg;
                        done_reg      <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        acc_reg <= acc_next;
                        ovf_reg <= ovf_next;
                        cnt_reg <= cnt_next;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // busy comes straight from the state so it falls in the same cycle that
    // done rises.
    assign busy      = (state_reg == CALC);
    assign done      = done_reg;
    assign overflow  = overflow_reg;
    assign fdata_out = fdata_out_reg;

endmodule : fact_engine
